debug_unit: RTL and testbench

- Host-side controller sitting directly upstream of the pipeline top. Exchanges bytes with a UART rx/tx pair.
- Loads program words into instruction memory through the pipeline's i_instruction / i_write inputs.
- Drives i_enable for continuous or single-step execution.
- After a halt or a step, reads PC, register file and data memory back through i_debug_addr and returns them byte-serially to the host.

---
 rtl/debug_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_debug_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller: loads program words from the UART, runs or single-steps the
// pipeline, then streams PC, register file and data memory back to the host MSB first.
module debug_unit #(
  parameter int INST_SZ = 32,
  parameter int PC_SZ   = 32,
  parameter int REG_SZ  = 5,
  parameter int BYTE_SZ = 8,
  parameter logic [BYTE_SZ-1:0] CMD_LOAD = 8'h4C,
  parameter logic [BYTE_SZ-1:0] CMD_CONT = 8'h43,
  parameter logic [BYTE_SZ-1:0] CMD_STEP = 8'h53
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic [INST_SZ-1:0] i_mem,
  input  logic               i_halt,
  output logic [BYTE_SZ-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_write,
  output logic               o_enable,
  output logic               o_pipe_reset,
  output logic [REG_SZ-1:0]  o_debug_addr
);
  localparam int WORD_BYTES = INST_SZ / BYTE_SZ;
  localparam int PC_BYTES   = PC_SZ / BYTE_SZ;
  localparam int SH_SZ      = (PC_SZ > INST_SZ) ? PC_SZ : INST_SZ;
  localparam int MAX_BYTES  = SH_SZ / BYTE_SZ;
  localparam int CNT_W      = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_WB = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CNT, S_LOAD_BYTE, S_LOAD_WRITE, S_PRST, S_RUN, S_STEP,
    S_DUMP_ADDR, S_DUMP_LATCH, S_DUMP_SEND, S_DUMP_WAIT
  } state_t;

  typedef enum logic [1:0] {SEC_PC, SEC_REG, SEC_MEM} sec_t;

  state_t             state_q, state_d;
  sec_t               sec_q, sec_d;
  logic [REG_SZ-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [BYTE_SZ-1:0] wcnt_q, wcnt_d;
  logic [BYTE_SZ-1:0] nwords_q, nwords_d;
  logic [SH_SZ-1:0]   shift_q, shift_d;
  logic [INST_SZ-1:0] instr_q, instr_d;
  logic [BYTE_SZ-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               write_q, write_d;
  logic               enable_q, enable_d;
  logic               pipe_reset_q, pipe_reset_d;
  logic [REG_SZ-1:0]  debug_addr_q, debug_addr_d;

  always_comb begin
    state_d      = state_q;
    sec_d        = sec_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    wcnt_d       = wcnt_q;
    nwords_d     = nwords_q;
    shift_d      = shift_q;
    instr_d      = instr_q;
    tx_data_d    = tx_data_q;
    debug_addr_d = debug_addr_q;
    tx_start_d   = 1'b0;
    write_d      = 1'b0;
    enable_d     = 1'b0;
    pipe_reset_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = S_LOAD_CNT;
            bcnt_d  = '0;
            wcnt_d  = '0;
          end else if (i_rx_data == CMD_CONT) begin
            state_d = S_RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_d  = S_STEP;
            enable_d = 1'b1;
          end
        end
      end
      S_LOAD_CNT: begin
        if (i_rx_done) begin
          nwords_d = i_rx_data;
          if (i_rx_data == '0) begin
            state_d      = S_PRST;
            pipe_reset_d = 1'b1;
          end else begin
            state_d = S_LOAD_BYTE;
          end
        end
      end
      S_LOAD_BYTE: begin
        if (i_rx_done) begin
          instr_d = {instr_q[INST_SZ-BYTE_SZ-1:0], i_rx_data};
          if (bcnt_q == LAST_WB) begin
            bcnt_d  = '0;
            wcnt_d  = wcnt_q + 1'b1;
            write_d = 1'b1;
            state_d = S_LOAD_WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      // The word counter was bumped on entry, so it already includes this write.
      S_LOAD_WRITE: begin
        if (wcnt_q == nwords_q) begin
          state_d      = S_PRST;
          pipe_reset_d = 1'b1;
        end else begin
          state_d = S_LOAD_BYTE;
        end
      end
      S_PRST: state_d = S_IDLE;
      S_RUN: begin
        if (i_halt) begin
          state_d = S_DUMP_ADDR;
          sec_d   = SEC_PC;
          idx_d   = '0;
        end else begin
          enable_d = 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_DUMP_ADDR;
        sec_d   = SEC_PC;
        idx_d   = '0;
      end
      S_DUMP_ADDR: begin
        debug_addr_d = idx_q;
        state_d      = S_DUMP_LATCH;
      end
      // Words are left-aligned in the shift register so bytes always leave from the top.
      S_DUMP_LATCH: begin
        state_d = S_DUMP_SEND;
        unique case (sec_q)
          SEC_PC: begin
            shift_d = SH_SZ'(i_pc) << (SH_SZ - PC_SZ);
            bcnt_d  = CNT_W'(PC_BYTES);
          end
          SEC_REG: begin
            shift_d = SH_SZ'(i_reg) << (SH_SZ - INST_SZ);
            bcnt_d  = CNT_W'(WORD_BYTES);
          end
          default: begin
            shift_d = SH_SZ'(i_mem) << (SH_SZ - INST_SZ);
            bcnt_d  = CNT_W'(WORD_BYTES);
          end
        endcase
      end
      S_DUMP_SEND: begin
        tx_data_d  = shift_q[SH_SZ-1 -: BYTE_SZ];
        tx_start_d = 1'b1;
        shift_d    = shift_q << BYTE_SZ;
        bcnt_d     = bcnt_q - 1'b1;
        state_d    = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (bcnt_q != '0) begin
            state_d = S_DUMP_SEND;
          end else if (sec_q == SEC_PC) begin
            sec_d   = SEC_REG;
            idx_d   = '0;
            state_d = S_DUMP_ADDR;
          end else if (idx_q != '1) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DUMP_ADDR;
          end else if (sec_q == SEC_REG) begin
            sec_d   = SEC_MEM;
            idx_d   = '0;
            state_d = S_DUMP_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      sec_q        <= SEC_PC;
      idx_q        <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      nwords_q     <= '0;
      shift_q      <= '0;
      instr_q      <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      write_q      <= 1'b0;
      enable_q     <= 1'b0;
      pipe_reset_q <= 1'b0;
      debug_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      wcnt_q       <= wcnt_d;
      nwords_q     <= nwords_d;
      shift_q      <= shift_d;
      instr_q      <= instr_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      write_q      <= write_d;
      enable_q     <= enable_d;
      pipe_reset_q <= pipe_reset_d;
      debug_addr_q <= debug_addr_d;
    end
  end

  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_instruction = instr_q;
  assign o_write       = write_q;
  assign o_enable      = enable_q;
  assign o_pipe_reset  = pipe_reset_q;
  assign o_debug_addr  = debug_addr_q;
endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: directed host commands; expected writes, pipeline resets and
// transmitted bytes are queued up front and matched by an independent output monitor.
module tb_debug_unit;
  logic        i_clk;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic        i_tx_done;
  logic [31:0] i_pc;
  logic [31:0] i_reg;
  logic [31:0] i_mem;
  logic        i_halt;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [31:0] o_instruction;
  logic        o_write;
  logic        o_enable;
  logic        o_pipe_reset;
  logic [4:0]  o_debug_addr;

  localparam logic [1:0] EV_WRITE = 2'd0;
  localparam logic [1:0] EV_PRST  = 2'd1;
  localparam logic [1:0] EV_TX    = 2'd2;

  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int en_total = 0;
  int ev_total = 0;
  int tx_starts = 0;
  int tx_dones  = 0;
  int tx_delay  = 2;
  int tx_timer  = 0;
  logic tx_pending = 1'b0;

  debug_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_halt(i_halt),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_instruction(o_instruction),
    .o_write(o_write), .o_enable(o_enable), .o_pipe_reset(o_pipe_reset),
    .o_debug_addr(o_debug_addr)
  );

  // Clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Pipeline model: register file and data memory contents as a function of address
  function automatic logic [31:0] reg_val(input int a);
    return 32'hA5000000 ^ (32'(a) * 32'h01030507);
  endfunction

  function automatic logic [31:0] mem_val(input int a);
    return 32'h3C0000FF ^ (32'(a) * 32'h0B0D0F11);
  endfunction

  assign i_reg = reg_val(int'(o_debug_addr));
  assign i_mem = mem_val(int'(o_debug_addr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back({EV_TX, 24'h0, w[8*b +: 8]});
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int a = 0; a < 32; a++) push_word(reg_val(a));
    for (int a = 0; a < 32; a++) push_word(mem_val(a));
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_pending) && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= budget) fail_now(name);
    repeat (5) @(negedge i_clk);
  endtask

  // Transmitter model: answers each o_tx_start with i_tx_done after tx_delay cycles
  always @(negedge i_clk) begin
    i_tx_done = 1'b0;
    if (i_reset) begin
      tx_pending = 1'b0;
    end else if (o_tx_start) begin
      check("tx_start_while_busy", 64'(tx_pending), 64'd0);
      tx_pending = 1'b1;
      tx_timer   = tx_delay;
      tx_starts++;
    end else if (tx_pending) begin
      if (tx_timer == 0) begin
        i_tx_done  = 1'b1;
        tx_pending = 1'b0;
        tx_dones++;
      end else begin
        tx_timer--;
      end
    end
  end

  // Scoreboard monitor
  task automatic pop_check(input string name, input logic [1:0] kind, input logic [31:0] data);
    logic [33:0] e;
    ev_total++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got %h with nothing expected at %0t", name, data, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'({kind, data}), 64'(e));
    end
  endtask

  always @(negedge i_clk) begin
    if (o_enable) en_total++;
    if (o_write) pop_check("write", EV_WRITE, o_instruction);
    if (o_pipe_reset) pop_check("pipe_reset", EV_PRST, 32'h0);
    if (o_tx_start) pop_check("tx_byte", EV_TX, 32'(o_tx_data));
  end

  // Stimulus
  initial begin
    int en0, tx0, ev0, cnt;
    logic done;
    i_reset = 1'b1; i_rx_data = 8'h0; i_rx_done = 1'b0; i_halt = 1'b0; i_pc = 32'hDEADBEEF;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    check("rst_tx_data", 64'(o_tx_data), 64'h0);
    check("rst_tx_start", 64'(o_tx_start), 64'h0);
    check("rst_instruction", 64'(o_instruction), 64'h0);
    check("rst_write", 64'(o_write), 64'h0);
    check("rst_enable", 64'(o_enable), 64'h0);
    check("rst_pipe_reset", 64'(o_pipe_reset), 64'h0);
    check("rst_debug_addr", 64'(o_debug_addr), 64'h0);

    // Load two words
    en0 = en_total;
    exp_q.push_back({EV_WRITE, 32'h20010005});
    exp_q.push_back({EV_WRITE, 32'hFFFFFFFF});
    exp_q.push_back({EV_PRST, 32'h0});
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    wait_done("load_timeout", 100);
    check("load_enable_cycles", 64'(en_total - en0), 64'd0);

    // Continuous run; pipeline halts after 7 enabled cycles
    en0 = en_total; tx0 = tx_starts;
    push_dump(32'hDEADBEEF);
    send_byte(8'h43);
    cnt = 0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge i_clk);
      if (o_enable) cnt++;
      if (cnt == 7) begin
        i_halt = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) fail_now("run_enable_timeout");
    wait_done("run_dump_timeout", 5000);
    i_halt = 1'b0;
    check("run_enable_cycles", 64'(en_total - en0), 64'd7);
    check("run_dump_bytes", 64'(tx_starts - tx0), 64'd260);

    // Single step under tx back-pressure; a load command mid-dump is ignored
    tx_delay = 50;
    i_pc = 32'h00000040;
    en0 = en_total; tx0 = tx_starts;
    push_dump(32'h00000040);
    send_byte(8'h53);
    repeat (200) @(negedge i_clk);
    send_byte(8'h4C);
    wait_done("step_dump_timeout", 20000);
    tx_delay = 2;
    check("step_enable_cycles", 64'(en_total - en0), 64'd1);
    check("step_dump_bytes", 64'(tx_starts - tx0), 64'd260);

    // Unknown byte in IDLE: no activity at all
    en0 = en_total; ev0 = ev_total;
    send_byte(8'h7A);
    repeat (30) @(negedge i_clk);
    check("unknown_events", 64'(ev_total - ev0), 64'd0);
    check("unknown_enable", 64'(en_total - en0), 64'd0);

    // Halt already high when run is requested: straight to dump, no enable
    i_pc = 32'h12345678;
    i_halt = 1'b1;
    en0 = en_total; tx0 = tx_starts;
    push_dump(32'h12345678);
    send_byte(8'h43);
    wait_done("halt_entry_timeout", 5000);
    i_halt = 1'b0;
    check("halt_entry_enable", 64'(en_total - en0), 64'd0);
    check("halt_entry_bytes", 64'(tx_starts - tx0), 64'd260);

    // Reset after two of four bytes, then a clean single-word load
    send_byte(8'h4C); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    check("midload_rst_instruction", 64'(o_instruction), 64'h0);
    check("midload_rst_write", 64'(o_write), 64'h0);
    exp_q.push_back({EV_WRITE, 32'h11223344});
    exp_q.push_back({EV_PRST, 32'h0});
    send_byte(8'h4C); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done("reload_timeout", 100);

    // Zero-word load goes straight to pipeline reset
    exp_q.push_back({EV_PRST, 32'h0});
    send_byte(8'h4C); send_byte(8'h00);
    wait_done("zero_load_timeout", 100);

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    check("tx_start_done_balance", 64'(tx_starts), 64'(tx_dones));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
